// File: rtl/rtib_core.sv
// Real-time input buffer: edge-triggered capture of TTL lines into a timestamped FWFT FIFO.
// Optional macro RTIB_INPUT_SYNC_EN inserts a 2-flop input synchronizer ahead of data_q.
module rtib_core #(
  parameter int unsigned THRESHOLD = 1000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_LEN  = 10,
  parameter int unsigned DATA_LEN  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                auto_start,
  input  logic                flush,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic [DATA_LEN-1:0] rise_mask,
  input  logic [DATA_LEN-1:0] fall_mask,
  input  logic [63:0]         counter,
  input  logic                read,
  output logic [127:0]        rti_out,
  output logic                overflow_error,
  output logic [127:0]        overflow_error_data,
  output logic                underflow_error,
  output logic [ADDR_LEN:0]   count,
  output logic                full,
  output logic                empty
);

  localparam int unsigned EntryW = 64 + DATA_LEN;
  localparam logic [ADDR_LEN:0] ThreshCnt = (ADDR_LEN + 1)'(THRESHOLD);

  logic [DATA_LEN-1:0] sample;
  logic [DATA_LEN-1:0] data_q, data_prev;
  logic                armed_q;
  logic [ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_LEN:0]   count_q, count_d;
  logic [EntryW-1:0]   mem [DEPTH];
  logic [EntryW-1:0]   head_q, head_d;
  logic [EntryW-1:0]   ovf_data_q;
  logic [EntryW-1:0]   entry;
  logic [DATA_LEN-1:0] ev;
  logic                ev_valid, do_write, do_drop, do_read, do_underflow;

`ifdef RTIB_INPUT_SYNC_EN
  logic [DATA_LEN-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = data_in;
`endif

  function automatic logic [127:0] widen(input logic [EntryW-1:0] e);
    widen = '0;
    widen[127:64] = e[EntryW-1 -: 64];
    widen[DATA_LEN-1:0] = e[DATA_LEN-1:0];
  endfunction

  assign full  = (count_q >= ThreshCnt);
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    ev           = (data_q & ~data_prev & rise_mask) | (~data_q & data_prev & fall_mask);
    entry        = {counter, data_q};
    // flush takes priority over any same-cycle event or pop
    ev_valid     = (|ev) && auto_start && armed_q && !flush;
    do_write     = ev_valid && !full;
    do_drop      = ev_valid && full;
    do_read      = read && !empty && !flush;
    do_underflow = read && empty && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + ADDR_LEN'(1);
      if (do_read)  rd_ptr_d = rd_ptr_q + ADDR_LEN'(1);
      if (do_write && !do_read)      count_d = count_q + (ADDR_LEN + 1)'(1);
      else if (do_read && !do_write) count_d = count_q - (ADDR_LEN + 1)'(1);
    end

    // Registered read of the next head; bypass covers a write landing on that slot.
    head_d = (do_write && (wr_ptr_q == rd_ptr_d)) ? entry : mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q          <= '0;
      data_prev       <= '0;
      armed_q         <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      head_q          <= '0;
      ovf_data_q      <= '0;
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else begin
      data_q          <= sample;
      data_prev       <= data_q;
      armed_q         <= auto_start && !flush;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      head_q          <= head_d;
      overflow_error  <= do_drop;
      underflow_error <= do_underflow;
      if (do_drop) ovf_data_q <= entry;
    end
  end

  always_comb begin
    rti_out = '0;
    if (!empty) rti_out = widen(head_q);
    overflow_error_data = widen(ovf_data_q);
  end

endmodule

// File: tb/tb_rtib_core.sv
// Self-checking bench for rtib_core: vector table plus scoreboard queue of expected entries.
module tb_rtib_core;

  logic         clk = 1'b0;
  logic         reset, auto_start, flush, read;
  logic [7:0]   data_in, rise_mask, fall_mask;
  logic [63:0]  counter;
  logic [127:0] rti_out, overflow_error_data;
  logic         overflow_error, underflow_error, full, empty;
  logic [10:0]  count;

  rtib_core #(
    .THRESHOLD(1000),
    .DEPTH    (1024),
    .ADDR_LEN (10),
    .DATA_LEN (8)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .auto_start         (auto_start),
    .flush              (flush),
    .data_in            (data_in),
    .rise_mask          (rise_mask),
    .fall_mask          (fall_mask),
    .counter            (counter),
    .read               (read),
    .rti_out            (rti_out),
    .overflow_error     (overflow_error),
    .overflow_error_data(overflow_error_data),
    .underflow_error    (underflow_error),
    .count              (count),
    .full               (full),
    .empty              (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [7:0] rm;
    logic [7:0] fm;
    bit         ev;
  } vec_t;

  int           vectors = 0;
  int           miscompares = 0;
  logic [127:0] sb[$];
  vec_t         tbl[12];
  logic [127:0] ov;
  logic [63:0]  last_ts;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge; counter advances once per cycle.
  task automatic step();
    @(posedge clk);
    #1;
    counter = counter + 64'd1;
  endtask

  function automatic logic [127:0] mk(input logic [63:0] ts, input logic [7:0] d);
    mk = '0;
    mk[127:64] = ts;
    mk[7:0] = d;
  endfunction

  // The event is evaluated in the next cycle, whose counter value is one higher.
  task automatic drive(input logic [7:0] d, input bit ev);
    data_in = d;
    if (ev) sb.push_back(mk(counter + 64'd1, d));
  endtask

  task automatic pop_check(input string name);
    logic [127:0] e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty, got %h expected none", name, rti_out);
    end else begin
      e = sb.pop_front();
      check(name, rti_out, e);
    end
    read = 1'b1;
    step();
    read = 1'b0;
  endtask

  initial begin
    reset = 1'b1; auto_start = 1'b0; flush = 1'b0; read = 1'b0;
    data_in = '0; rise_mask = '0; fall_mask = '0; counter = '0;
    repeat (3) step();
    check("rst_rti_out", rti_out, '0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow_error, 0);
    check("rst_unf", underflow_error, 0);
    check("rst_ovf_data", overflow_error_data, '0);
    reset = 1'b0;

    // Line0 pulse: rise stamped 100, fall stamped 105.
    auto_start = 1'b1; rise_mask = 8'hFF; fall_mask = 8'hFF;
    repeat (3) step();
    counter = 64'd99;
    drive(8'h01, 1);
    for (int i = 0; i < 10 && counter != 64'd104; i++) step();
    drive(8'h00, 1);
    step(); step();
    check("pulse_count", count, 2);
    check("pulse_e0", sb[0], mk(64'd100, 8'h01));
    pop_check("pulse_pop0");
    pop_check("pulse_pop1");
    check("pulse_empty", empty, 1);

    // Lines already high when capture starts produce nothing.
    auto_start = 1'b0;
    data_in = 8'h03;
    repeat (3) step();
    auto_start = 1'b1; rise_mask = 8'h01; fall_mask = 8'h00;
    repeat (4) step();
    check("prehigh_count", count, 0);

    tbl[0]  = '{8'h01, 8'hFF, 8'hFF, 1'b1};
    tbl[1]  = '{8'h00, 8'hFF, 8'hFF, 1'b1};
    tbl[2]  = '{8'h03, 8'h01, 8'h00, 1'b1};
    tbl[3]  = '{8'h01, 8'h01, 8'h00, 1'b0};
    tbl[4]  = '{8'h03, 8'h01, 8'h00, 1'b0};
    tbl[5]  = '{8'h02, 8'hFF, 8'h02, 1'b0};
    tbl[6]  = '{8'h00, 8'h00, 8'h02, 1'b1};
    tbl[7]  = '{8'hF0, 8'h80, 8'h00, 1'b1};
    tbl[8]  = '{8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[9]  = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
    tbl[10] = '{8'h7F, 8'h00, 8'h80, 1'b1};
    tbl[11] = '{8'h7F, 8'h00, 8'h00, 1'b0};
    for (int i = 0; i < 12; i++) begin
      rise_mask = tbl[i].rm;
      fall_mask = tbl[i].fm;
      drive(tbl[i].d, tbl[i].ev);
      step(); step();
      check("tbl_count", count, sb.size());
    end
    for (int i = 0; i < 12 && sb.size() > 0; i++) pop_check("tbl_pop");
    check("tbl_empty", empty, 1);

    // Fill to the threshold, then one dropped event.
    rise_mask = 8'hFF; fall_mask = 8'hFF;
    for (int i = 0; i < 1000; i++) begin
      drive(data_in ^ 8'h01, 1);
      step();
    end
    step();
    check("fill_count", count, 1000);
    check("fill_full", full, 1);
    check("fill_ovf_idle", overflow_error, 0);
    ov = mk(counter + 64'd1, data_in ^ 8'h01);
    data_in = data_in ^ 8'h01;
    step();
    check("drop_ovf_early", overflow_error, 0);
    step();
    check("drop_ovf", overflow_error, 1);
    check("drop_ovf_data", overflow_error_data, ov);
    check("drop_count", count, 1000);
    step();
    check("drop_ovf_pulse", overflow_error, 0);

    // Pop while events keep arriving; write pointer wraps past 1023.
    last_ts = rti_out[127:64];
    pop_check("wrap_pop0");
    for (int i = 0; i < 1000; i++) begin
      check("ts_mono", rti_out[127:64] > last_ts, 1);
      last_ts = rti_out[127:64];
      pop_check("wrap_pop");
      read = 1'b1;
      drive(data_in ^ 8'h01, 1);
    end
    read = 1'b0;
    step(); step();
    check("wrap_count", count, 999);
    for (int i = 0; i < 1000 && sb.size() > 10; i++) pop_check("drain_pop");
    check("drain_count", count, 10);

    // Flush with an edge in flight: nothing may be captured afterwards.
    flush = 1'b1;
    data_in = data_in ^ 8'h01;
    step();
    flush = 1'b0;
    sb.delete();
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_rti_out", rti_out, '0);
    repeat (3) step();
    check("flush_no_spurious", count, 0);

    // Simultaneous write and read at count 5, then underflow.
    for (int i = 0; i < 5; i++) begin
      drive(data_in ^ 8'h01, 1);
      step(); step();
    end
    check("simul_pre_count", count, 5);
    drive(data_in ^ 8'h01, 1);
    step();
    pop_check("simul_pop");
    check("simul_count", count, 5);
    for (int i = 0; i < 6 && sb.size() > 0; i++) pop_check("simul_drain");
    check("simul_empty", empty, 1);
    read = 1'b1;
    step();
    read = 1'b0;
    check("unf_pulse", underflow_error, 1);
    check("unf_count", count, 0);
    step();
    check("unf_clear", underflow_error, 0);

    // Reset while capturing with entries stored.
    drive(data_in ^ 8'h01, 1);
    step(); step();
    data_in = 8'h00;
    step();
    reset = 1'b1;
    step();
    check("rst2_count", count, 0);
    check("rst2_empty", empty, 1);
    check("rst2_rti_out", rti_out, '0);
    check("rst2_ovf_data", overflow_error_data, '0);
    reset = 1'b0;
    repeat (3) step();
    check("rst2_idle_count", count, 0);
    check("rst2_full", full, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
